// File: rtl/pwm_pkg.sv
// Shared constants for the PWM duty-cycle ramp sequencer.
package pwm_pkg;
  localparam int PWM_WIDTH     = 8;
  localparam int PWM_DIV_WIDTH = 16;
  localparam int STEP_ZERO_SUB = 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RAMP = 1'b1;
endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Command/status bundle between a ramp requester and pwm_ramp_ctrl.
// The done signal exists only when PWM_RAMP_DONE_EN is defined.
interface pwm_ramp_ctrl_if import pwm_pkg::*; #(
  parameter int WIDTH     = PWM_WIDTH,
  parameter int DIV_WIDTH = PWM_DIV_WIDTH
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [WIDTH-1:0]     cmd_target;
  logic [WIDTH-1:0]     cmd_step;
  logic [DIV_WIDTH-1:0] cmd_div;
  logic                 abort;
  logic [WIDTH-1:0]     duty_cycle;
  logic                 busy;
`ifdef PWM_RAMP_DONE_EN
  logic                 done;
`endif

  modport master (
    output cmd_valid, cmd_target, cmd_step, cmd_div, abort,
`ifdef PWM_RAMP_DONE_EN
    input  done,
`endif
    input  cmd_ready, duty_cycle, busy
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_step, cmd_div, abort,
`ifdef PWM_RAMP_DONE_EN
    output done,
`endif
    output cmd_ready, duty_cycle, busy
  );
endinterface

// File: rtl/pwm_tick_div.sv
// Loadable down-counter that holds at zero; tick is high while the count is zero.
module pwm_tick_div #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_tick
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                  r_cnt <= '0;
    else if (i_load)               r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0)  r_cnt <= r_cnt - W'(1);
  end

  assign o_tick = (r_cnt == '0);
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer feeding PWM.DUTY_CYCLE; steps toward a target without overshoot.
// Optional DONE pulse is compiled in with PWM_RAMP_DONE_EN.
module pwm_ramp_ctrl import pwm_pkg::*; #(
  parameter int WIDTH     = PWM_WIDTH,
  parameter int DIV_WIDTH = PWM_DIV_WIDTH
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  pwm_ramp_ctrl_if.slave bus
);
  logic [0:0]           r_state;
  logic [WIDTH-1:0]     r_duty, r_tgt, r_step;
  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_busy;

  logic                 w_accept, w_tick, w_step_now, w_load, w_up, w_reached;
  logic [WIDTH:0]       w_mag;
  logic [WIDTH-1:0]     w_delta, w_next, w_step_in;
  logic [DIV_WIDTH-1:0] w_load_val;

  assign bus.cmd_ready  = (r_state == ST_IDLE) && !bus.abort;
  assign bus.duty_cycle = r_duty;
  assign bus.busy       = r_busy;

  assign w_accept  = bus.cmd_valid && bus.cmd_ready;
  assign w_step_in = (bus.cmd_step == '0) ? WIDTH'(STEP_ZERO_SUB) : bus.cmd_step;

  // Distance is taken one bit wider so neither direction can wrap.
  assign w_up      = r_tgt > r_duty;
  assign w_mag     = w_up ? ({1'b0, r_tgt} - {1'b0, r_duty}) : ({1'b0, r_duty} - {1'b0, r_tgt});
  assign w_delta   = (w_mag < {1'b0, r_step}) ? w_mag[WIDTH-1:0] : r_step;
  assign w_next    = w_up ? (r_duty + w_delta) : (r_duty - w_delta);
  assign w_reached = (w_next == r_tgt);

  // Abort wins over a coincident update.
  assign w_step_now = (r_state == ST_RAMP) && !bus.abort && w_tick;
  assign w_load     = w_accept || w_step_now;
  assign w_load_val = w_accept ? bus.cmd_div : r_div;

  pwm_tick_div #(.W(DIV_WIDTH)) u_div (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (r_state == ST_RAMP),
    .o_tick     (w_tick)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_duty  <= '0;
      r_tgt   <= '0;
      r_step  <= '0;
      r_div   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_tgt  <= bus.cmd_target;
            r_step <= w_step_in;
            r_div  <= bus.cmd_div;
            if (bus.cmd_target != r_duty) begin
              r_state <= ST_RAMP;
              r_busy  <= 1'b1;
            end
          end
        end
        default: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_tick) begin
            r_duty <= w_next;
            if (w_reached) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

`ifdef PWM_RAMP_DONE_EN
  logic r_done, w_fin;

  // Zero-length commands complete at acceptance.
  assign w_fin = (w_accept && bus.cmd_target == r_duty) || (w_step_now && w_reached);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_done <= 1'b0;
    else          r_done <= w_fin;
  end

  assign bus.done = r_done;
`endif
endmodule
